// File: rtl/ethernet_sys_frame_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ethernet_sys_frame_reader_if : control, memory-read and Avalon-ST bundle
// Revision: 1.0
// ============================================================================
interface ethernet_sys_frame_reader_if #(
    parameter int ADDR_W = 13
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       byte_len;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_readdata;

    logic [31:0]       src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;
    logic [1:0]        src_empty;

    modport master (
        input  start, base_addr, byte_len, mem_readdata, src_ready,
        output busy, done, mem_address, mem_chipselect, mem_clken, mem_write,
               mem_byteenable, src_data, src_valid, src_sop, src_eop, src_empty
    );

    modport slave (
        output start, base_addr, byte_len, mem_readdata, src_ready,
        input  busy, done, mem_address, mem_chipselect, mem_clken, mem_write,
               mem_byteenable, src_data, src_valid, src_sop, src_eop, src_empty
    );
endinterface
`default_nettype wire

// File: rtl/ethernet_sys_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ethernet_sys_frame_reader : streams a frame from word memory to Avalon-ST
// Revision: 1.0
// ============================================================================
module ethernet_sys_frame_reader #(
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    ethernet_sys_frame_reader_if.master bus
);
    localparam int               c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int               c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [14:0]         r_words_left;
    logic [1:0]          r_empty;
    logic                r_done;
    logic                r_rd_pending;
    logic                r_rd_sop;
    logic                r_rd_eop;
    // Entry layout: {sop, eop, data}
    logic [33:0]         r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic [14:0]         w_words;
    logic                w_credit;
    logic                w_valid;
    logic [33:0]         w_head;
    logic                w_pop;
    logic                w_issue;
    logic                w_issue_sop;
    logic                w_issue_eop;
    logic                w_load;
    logic                w_done_next;
    logic [31:0]         w_swapped;

    assign w_words   = {1'b0, bus.byte_len[15:2]} + {14'd0, |bus.byte_len[1:0]};
    // Reads are only issued while a slot is guaranteed for the returning word
    assign w_credit  = (r_count + c_cnt_w'(r_rd_pending)) < c_depth;
    assign w_valid   = (r_count != '0);
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_pop     = w_valid & bus.src_ready;
    assign w_swapped = {bus.mem_readdata[7:0],   bus.mem_readdata[15:8],
                        bus.mem_readdata[23:16], bus.mem_readdata[31:24]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first read goes out in the start cycle itself to meet start-to-valid latency
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_sop  = 1'b0;
        w_issue_eop  = 1'b0;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.byte_len == 16'd0) begin
                            w_done_next = 1'b1;
                        end else begin
                            w_load       = 1'b1;
                            w_issue      = 1'b1;
                            w_issue_sop  = 1'b1;
                            w_issue_eop  = (w_words == 15'd1);
                            w_state_next = (w_words == 15'd1) ? S_DRAIN : S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_credit) begin
                        w_issue     = 1'b1;
                        w_issue_eop = (r_words_left == 15'd1);
                        if (r_words_left == 15'd1) begin
                            w_state_next = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head[32]) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_empty      <= 2'd0;
            r_done       <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_sop     <= 1'b0;
            r_rd_eop     <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_done       <= w_done_next;
            r_rd_pending <= w_issue;
            r_rd_sop     <= w_issue_sop;
            r_rd_eop     <= w_issue_eop;
            if (w_load) begin
                r_addr       <= bus.base_addr + ADDR_W'(1);
                r_words_left <= w_words - 15'd1;
                r_empty      <= 2'd0 - bus.byte_len[1:0];
            end else if (w_issue) begin
                r_addr       <= r_addr + ADDR_W'(1);
                r_words_left <= r_words_left - 15'd1;
            end
            if (r_rd_pending) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({r_rd_pending, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_pending) begin
            r_fifo[r_wr_ptr] <= {r_rd_sop, r_rd_eop, w_swapped};
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = r_done;
    assign bus.mem_address    = w_load ? bus.base_addr : r_addr;
    assign bus.mem_chipselect = w_issue;
    assign bus.mem_clken      = 1'b1;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.src_valid      = w_valid;
    assign bus.src_data       = w_head[31:0];
    assign bus.src_sop        = w_valid & w_head[33];
    assign bus.src_eop        = w_valid & w_head[32];
    assign bus.src_empty      = (w_valid & w_head[32]) ? r_empty : 2'd0;
endmodule
`default_nettype wire

// File: tb/tb_ethernet_sys_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ethernet_sys_frame_reader : directed bench for the frame reader
// Revision: 1.0
// ============================================================================
module tb_ethernet_sys_frame_reader;
    localparam int ADDR_W     = 13;
    localparam int FIFO_DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ethernet_sys_frame_reader_if #(.ADDR_W(ADDR_W)) bus ();

    ethernet_sys_frame_reader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:8191];
    always @(posedge clk) begin
        bus.mem_readdata <= bus.mem_chipselect ? mem[bus.mem_address] : 32'hDEADBEEF;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:0+24]};
    endfunction

    // Beat record: {data, sop, eop, empty}
    logic [35:0]       beat_q [$];
    logic [ADDR_W-1:0] rd_q   [$];
    int cyc = 0, start_cyc = -1, first_valid_cyc = -1, first_beat_cyc = -1;
    int eop_cyc = -1, done_cyc = -1, done_cnt = 0, outstanding = 0, max_out = 0;
    logic busy_at_done = 1'b0;
    logic prev_stall = 1'b0;
    logic [35:0] prev_beat = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (bus.start && !bus.busy) start_cyc = cyc;
            if (prev_stall)
                chk("hold", {bus.src_valid, bus.src_data, bus.src_sop, bus.src_eop, bus.src_empty},
                    {1'b1, prev_beat});
            if (bus.mem_chipselect) begin
                rd_q.push_back(bus.mem_address);
                outstanding++;
            end
            if (bus.src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.src_valid && bus.src_ready) begin
                beat_q.push_back({bus.src_data, bus.src_sop, bus.src_eop, bus.src_empty});
                outstanding--;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (bus.src_eop) eop_cyc = cyc;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (bus.done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = bus.busy;
            end
            prev_stall = bus.src_valid && !bus.src_ready;
            prev_beat  = {bus.src_data, bus.src_sop, bus.src_eop, bus.src_empty};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_q.delete();
        rd_q.delete();
        start_cyc = -1; first_valid_cyc = -1; first_beat_cyc = -1;
        eop_cyc = -1; done_cyc = -1; done_cnt = 0; max_out = 0;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [15:0] len);
        bus.base_addr = base;
        bus.byte_len  = len;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rnd, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            bus.src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        bus.src_ready = 1'b1;
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        tick();
    endtask

    task automatic chk_frame(input string tag, input logic [ADDR_W-1:0] base, input logic [15:0] len);
        int n;
        n = (int'(len) + 3) / 4;
        chk({tag, "_nbeats"}, 64'(beat_q.size()), 64'(n));
        chk({tag, "_nreads"}, 64'(rd_q.size()), 64'(n));
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            logic [ADDR_W-1:0] a;
            logic              eop;
            logic [35:0]       exp;
            a   = ADDR_W'(int'(base) + i);
            eop = (i == n - 1);
            exp = {bswap(mem[a]), (i == 0), eop, eop ? 2'((4 - int'(len % 4)) % 4) : 2'd0};
            chk($sformatf("%s_beat%0d", tag, i), beat_q[i], exp);
            if (i < rd_q.size()) chk($sformatf("%s_addr%0d", tag, i), rd_q[i], a);
        end
        chk({tag, "_done_after_eop"}, 64'(done_cyc - eop_cyc), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_outs"}, {bus.busy, bus.done, bus.mem_chipselect, bus.src_valid,
                             bus.src_sop, bus.src_eop, bus.src_empty}, 64'd0);
        chk({tag, "_addr"}, bus.mem_address, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {3'b101, 13'(i), 16'(i * 40503)};
        mem[13'h10] = 32'h44332211;
        mem[13'h11] = 32'h88776655;
        mem[13'h12] = 32'h00CCBBAA;
        bus.start = 1'b0; bus.base_addr = '0; bus.byte_len = '0; bus.src_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        chk_reset_outs("rst");
        chk("rst_ties", {bus.mem_clken, bus.mem_write, bus.mem_byteenable}, 64'b1_0_1111);
        reset_n = 1'b1;
        tick();

        // 11-byte frame with hand-computed beats
        clear_mon();
        start_frame(13'h10, 16'd11);
        wait_done("t1", 1'b0, 100);
        chk("t1_nbeats", 64'(beat_q.size()), 64'd3);
        chk("t1_beat0", beat_q[0], 36'h112233448);
        chk("t1_beat1", beat_q[1], 36'h556677880);
        chk("t1_beat2", beat_q[2], 36'hAABBCC005);
        chk("t1_latency", 64'(first_valid_cyc >= 0 && first_valid_cyc - start_cyc <= 2), 64'd1);
        chk("t1_done_after_eop", 64'(done_cyc - eop_cyc), 64'd1);
        chk("t1_busy_at_done", 64'(busy_at_done), 64'd0);

        // single-beat frame
        clear_mon();
        start_frame(13'h10, 16'd4);
        wait_done("t2", 1'b0, 100);
        chk("t2_nbeats", 64'(beat_q.size()), 64'd1);
        chk("t2_beat0", beat_q[0], 36'h11223344C);

        // zero-length frame
        clear_mon();
        start_frame(13'h10, 16'd0);
        repeat (4) tick();
        chk("t3_reads", 64'(rd_q.size()), 64'd0);
        chk("t3_valid", 64'(first_valid_cyc), 64'(-1));
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk("t3_done_lat", 64'(done_cyc - start_cyc), 64'd1);

        // address wrap
        clear_mon();
        start_frame(13'h1FFE, 16'd16);
        wait_done("t4", 1'b0, 100);
        chk("t4_a0", rd_q[0], 13'h1FFE);
        chk("t4_a1", rd_q[1], 13'h1FFF);
        chk("t4_a2", rd_q[2], 13'h0000);
        chk("t4_a3", rd_q[3], 13'h0001);
        chk_frame("t4", 13'h1FFE, 16'd16);

        // random backpressure
        clear_mon();
        start_frame(13'h200, 16'd64);
        wait_done("t5", 1'b1, 1000);
        chk_frame("t5", 13'h200, 16'd64);
        chk("t5_max_out", 64'(max_out <= FIFO_DEPTH), 64'd1);

        // sustained throughput
        clear_mon();
        start_frame(13'h300, 16'd32);
        wait_done("t6", 1'b0, 100);
        chk_frame("t6", 13'h300, 16'd32);
        chk("t6_rate", 64'(eop_cyc - first_beat_cyc), 64'd7);

        // start while busy is ignored
        clear_mon();
        start_frame(13'h20, 16'd12);
        bus.base_addr = 13'h40; bus.byte_len = 16'd40; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("t7", 1'b0, 100);
        repeat (5) tick();
        chk_frame("t7", 13'h20, 16'd12);
        chk("t7_done_cnt", 64'(done_cnt), 64'd1);

        // reset mid-frame, then a clean frame right after
        clear_mon();
        start_frame(13'h400, 16'd64);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        chk_reset_outs("t8_rst");
        chk("t8_no_eop", 64'(eop_cyc), 64'(-1));
        reset_n = 1'b1;
        clear_mon();
        start_frame(13'h10, 16'd11);
        wait_done("t8", 1'b0, 100);
        chk_frame("t8", 13'h10, 16'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/ethernet_sys_frame_reader.md
ETHERNET_SYS_FRAME_READER -- requirements
Module: ethernet_sys_frame_reader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 13, memory word-address width.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-003 SHALL provide port clk  input  1  single clock for all logic.
REQ-004 SHALL provide port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port start  input  1  one-cycle request to transmit a frame.
REQ-006 SHALL provide port base_addr  input  ADDR_W  word address of the first frame word, sampled with start.
REQ-007 SHALL provide port byte_len  input  16  frame length in bytes, sampled with start.
REQ-008 SHALL provide port busy  output  1  high from accepted start until done.
REQ-009 SHALL provide port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL provide port mem_address  output  ADDR_W  read word address to on-chip memory port.
REQ-011 SHALL provide port mem_chipselect  output  1  read request qualifier.
REQ-012 SHALL provide port mem_clken  output  1  memory clock enable, tied high.
REQ-013 SHALL provide port mem_write  output  1  tied low.
REQ-014 SHALL provide port mem_byteenable  output  4  tied 4'hF.
REQ-015 SHALL provide port mem_readdata  input  32  read data, valid exactly one cycle after the request.
REQ-016 SHALL provide ports src_data (output, 32), src_valid (output, 1), src_ready (input, 1), src_sop (output, 1), src_eop (output, 1), src_empty (output, 2): Avalon-ST frame source toward the MAC.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start with byte_len!=0; FETCH->DRAIN when last word requested; DRAIN->IDLE when eop beat accepted.
REQ-018 SHALL, on start with byte_len==0, pulse done the next cycle, emit no beats and issue no reads.
REQ-019 SHALL ignore start while busy is high.
REQ-020 SHALL compute word count as ceil(byte_len/4) and request words base_addr, base_addr+1, ... with addresses wrapping modulo 2^ADDR_W.
REQ-021 SHALL assert mem_chipselect in a cycle only when FIFO occupancy plus in-flight reads is below FIFO_DEPTH; one read in flight per request, fixed latency 1.
REQ-022 SHALL write mem_readdata into the FIFO the cycle after each request; FIFO never overflows under any src_ready pattern.
REQ-023 SHALL present byte at lowest address on src_data[31:24] (byte lane 0 of mem_readdata -> src_data[31:24]).
REQ-024 SHALL assert src_valid whenever FIFO non-empty; beat transfers on src_valid & src_ready; src_data/sop/eop/empty held stable while src_valid & !src_ready.
REQ-025 SHALL assert src_sop on the first beat only, src_eop on the last beat only; both on a single-beat frame.
REQ-026 SHALL drive src_empty = (4 - byte_len mod 4) mod 4 on the eop beat, 0 on all other beats.
REQ-027 SHALL assert done one cycle after the eop beat transfers, with busy deasserting in that same cycle.
REQ-028 SHALL achieve one beat per clock sustained throughput when src_ready is held high; first src_valid no later than 2 cycles after start.

Reset
REQ-029 SHALL, while reset_n low at a clk edge, enter IDLE, flush FIFO, discard in-flight reads, and drive busy=0, done=0, mem_chipselect=0, src_valid=0, src_sop=0, src_eop=0, src_empty=0, mem_address=0.
REQ-030 SHALL, on reset mid-frame, abandon the frame without emitting eop and accept a new start the first cycle after reset_n returns high.

Verification
REQ-031 SHALL verify: memory words 0x10..0x12 = 0x44332211,0x88776655,0x00CCBBAA; start base_addr=0x10, byte_len=11, src_ready=1 -> beats 0x11223344(sop), 0x55667788, 0xAABBCC00(eop, empty=1), then done pulse.
REQ-032 SHALL verify: byte_len=64, src_ready toggling 1/0 randomly -> 16 beats in address order, no loss or duplication, never more than FIFO_DEPTH outstanding.
REQ-033 SHALL verify: base_addr=0x1FFE, byte_len=16 -> reads at 0x1FFE,0x1FFF,0x0000,0x0001.
REQ-034 SHALL verify: byte_len=0 -> no mem_chipselect, no src_valid, done pulses one cycle after start; byte_len=4 -> single beat with sop=eop=1, empty=0.
REQ-035 SHALL verify: start asserted again while busy -> ignored; reset_n low mid-frame -> all outputs at reset values next cycle, subsequent frame correct.
